// File: rtl/debug_snapshot_ctrl.sv
// Debug snapshot sequencer: freeze pipeline, sweep 32 debug channels into a buffer, stream it out.
// Define DBG_SNAP_CKSUM_EN to append an XOR checksum word (index 32) to each stream.
module debug_snapshot_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  Debug_addr,
    input  logic [31:0] Test_signal,
    output logic        cpu_freeze,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [7:0]  snap_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCAN,
        ST_STREAM
    } state_t;

`ifdef DBG_SNAP_CKSUM_EN
    localparam logic [5:0] LAST_IDX = 6'd32;
`else
    localparam logic [5:0] LAST_IDX = 6'd31;
`endif
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [5:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] snap_q [32];

    // idx_q is the channel select during SCAN and the word pointer during STREAM
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        if (abort) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            idx_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                        idx_d    = '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                ST_SCAN: begin
                    if (idx_q == 6'd31) begin
                        state_d = ST_STREAM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                            cnt_d   = cnt_q + 8'd1;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer content is only meaningful after a complete SCAN, so it carries no reset
    always_ff @(posedge clk) begin
        if (state_q == ST_SCAN) begin
            snap_q[idx_q[4:0]] <= Test_signal;
        end
    end

`ifdef DBG_SNAP_CKSUM_EN
    logic [31:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (state_q == ST_SETTLE) begin
            cksum_d = '0;
        end else if (state_q == ST_SCAN) begin
            cksum_d = cksum_q ^ Test_signal;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end
`endif

    always_comb begin
        out_data = '0;
        if (state_q == ST_STREAM) begin
`ifdef DBG_SNAP_CKSUM_EN
            out_data = (idx_q == LAST_IDX) ? cksum_q : snap_q[idx_q[4:0]];
`else
            out_data = snap_q[idx_q[4:0]];
`endif
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign cpu_freeze = (state_q == ST_SETTLE) || (state_q == ST_SCAN);
    assign Debug_addr = (state_q == ST_SCAN) ? idx_q[4:0] : 5'd0;
    assign out_valid  = (state_q == ST_STREAM);
    assign out_index  = (state_q == ST_STREAM) ? idx_q : 6'd0;
    assign out_last   = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
    assign done       = done_q;
    assign snap_cnt   = cnt_q;

endmodule
